// File: rtl/simd_booth_pkg.sv
// Shared types and helpers for the SIMD Booth multiplier controller.
// Holds the state encoding, lane-mode encodings and the iteration-count rule.
package simd_booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0] MODE_1X   = 2'b00;
  localparam logic [1:0] MODE_2X   = 2'b01;
  localparam logic [1:0] MODE_4X   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // Booth steps per lane: one per bit for radix-2, one per bit pair for radix-4.
  function automatic int iter_count(input int width, input int radix, input logic [1:0] mode);
    int lane_w;
    lane_w = (mode == MODE_RSVD) ? width : (width >> mode);
    return (radix == 4) ? (lane_w / 2) : lane_w;
  endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: clearable, enabled up-counter that saturates at
// the terminal value and flags the final iteration.
module booth_iter_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          hold,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] count,
  output logic          last_iter
);

  logic tc;

  assign tc        = (count == term);
  assign last_iter = en & tc;

  // Stops at the terminal value so the index never runs past the lane length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !hold && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/simd_booth_ctrl.sv
// Control FSM for a lane-configurable Booth multiplier: sequences operand
// load, the add/shift iterations and the result handshake.
module simd_booth_ctrl
  import simd_booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADIX = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     res_ack,
  input  logic                     abort,
  output logic                     start_ready,
  output logic                     ld_op,
  output logic                     clr_acc,
  output logic                     clr_count,
  output logic                     shift_en,
  output logic                     last_iter,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic [1:0]               lane_cfg,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH);

  if ((WIDTH % 4 != 0) || (WIDTH < 8) || ((RADIX != 2) && (RADIX != 4))) begin : g_bad_param
    $fatal(1, "simd_booth_ctrl: WIDTH must be a multiple of 4 and >= 8, RADIX must be 2 or 4");
  end

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic [CW-1:0] term;

  assign accept = (state == S_IDLE) && start && !abort;
  assign term   = CW'(iter_count(WIDTH, RADIX, lane_cfg) - 1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: if (res_ack || abort) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lane_cfg    <= MODE_1X;
      start_ready <= 1'b1;
      ld_op       <= 1'b0;
      clr_acc     <= 1'b0;
      clr_count   <= 1'b0;
      shift_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      if (accept) lane_cfg <= (mode == MODE_RSVD) ? MODE_1X : mode;
      start_ready <= (state_nxt == S_IDLE);
      ld_op       <= (state_nxt == S_LOAD);
      clr_acc     <= (state_nxt == S_LOAD);
      clr_count   <= (state_nxt == S_LOAD);
      shift_en    <= (state_nxt == S_RUN);
      busy        <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
      done        <= (state_nxt == S_DONE);
    end
  end

  // An abort freezes the counter so the index of the cancelled step stays visible.
  booth_iter_cnt #(
    .CW(CW)
  ) u_iter_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_count & ~abort),
    .en        (shift_en),
    .hold      (abort),
    .term      (term),
    .count     (count),
    .last_iter (last_iter)
  );

endmodule

// File: tb/tb_simd_booth_ctrl.sv
// Self-checking bench for simd_booth_ctrl: radix-2 and radix-4 instances
// driven in parallel against a cycle-since-accept reference model.
module tb_simd_booth_ctrl;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic res_ack = 1'b0;
  logic abort = 1'b0;
  logic [1:0] mode = 2'b00;

  logic sr2, ld2, ca2, cc2, se2, li2, bz2, dn2;
  logic sr4, ld4, ca4, cc4, se4, li4, bz4, dn4;
  logic [CW-1:0] cnt2, cnt4;
  logic [1:0] lc2, lc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simd_booth_ctrl #(.WIDTH(WIDTH), .RADIX(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .res_ack(res_ack), .abort(abort),
    .start_ready(sr2), .ld_op(ld2), .clr_acc(ca2), .clr_count(cc2), .shift_en(se2),
    .last_iter(li2), .count(cnt2), .lane_cfg(lc2), .busy(bz2), .done(dn2)
  );

  simd_booth_ctrl #(.WIDTH(WIDTH), .RADIX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .res_ack(res_ack), .abort(abort),
    .start_ready(sr4), .ld_op(ld4), .clr_acc(ca4), .clr_count(cc4), .shift_en(se4),
    .last_iter(li4), .count(cnt4), .lane_cfg(lc4), .busy(bz4), .done(dn4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an operation is "t cycles since acceptance".
  // t=1 load, t=2..n+1 iterations, t>=n+2 result held.
  typedef struct {
    bit         act;
    int         t;
    int         n;
    logic [1:0] lane;
    int         ch;
  } mdl_t;

  localparam mdl_t MRST = '{act: 1'b0, t: 0, n: 1, lane: 2'b00, ch: 0};
  mdl_t m2 = MRST;
  mdl_t m4 = MRST;

  function automatic mdl_t mstep(input mdl_t m, input logic s, input logic [1:0] md,
                                 input logic ack, input logic ab, input int radix);
    mdl_t r;
    r = m;
    if (!m.act) begin
      if (s && !ab) begin
        r.act  = 1'b1;
        r.t    = 1;
        r.lane = (md == 2'b11) ? 2'b00 : md;
        r.n    = (WIDTH >> r.lane) / ((radix == 4) ? 2 : 1);
      end
    end else if (m.t <= m.n + 1) begin
      if (ab) begin
        r.act = 1'b0;
        if (m.t >= 2) r.ch = m.t - 2;
      end else begin
        if (m.t == m.n + 1) r.ch = m.n - 1;
        r.t = m.t + 1;
      end
    end else if (ack || ab) begin
      r.act = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [14:0] mexp(input mdl_t m);
    logic sr, ld, sh, li, bz, dn;
    int c;
    sr = 0; ld = 0; sh = 0; li = 0; bz = 0; dn = 0; c = m.ch;
    if (!m.act) sr = 1;
    else if (m.t == 1) begin ld = 1; bz = 1; end
    else if (m.t <= m.n + 1) begin
      sh = 1; bz = 1; c = m.t - 2; li = (m.t == m.n + 1);
    end else dn = 1;
    return {sr, ld, ld, ld, sh, li, bz, dn, m.lane, CW'(c)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2 <= MRST;
      m4 <= MRST;
    end else begin
      m2 <= mstep(m2, start, mode, res_ack, abort, 2);
      m4 <= mstep(m4, start, mode, res_ack, abort, 4);
    end
  end

  always @(negedge clk) begin
    check("cyc_r2", {sr2, ld2, ca2, cc2, se2, li2, bz2, dn2, lc2, cnt2}, mexp(m2));
    check("cyc_r4", {sr4, ld4, ca4, cc4, se4, li4, bz4, dn4, lc4, cnt4}, mexp(m4));
  end

  typedef struct {
    logic [1:0] mode;
    logic [1:0] lane;
    int         sh2;
    int         dn2;
    int         sh4;
    int         dn4;
  } vec_t;

  vec_t vt[4];

  task automatic run_vec(input vec_t v, input string tag);
    int fld, fsh, nsh2, ddn2, nsh4, ddn4;
    fld = 0; fsh = 0; nsh2 = 0; ddn2 = 0; nsh4 = 0; ddn4 = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = v.mode;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
      end
      if (ld2 && fld == 0) fld = c;
      if (se2) begin
        nsh2++;
        if (fsh == 0) fsh = c;
      end
      if (se4) nsh4++;
      if (dn2 && ddn2 == 0) ddn2 = c;
      if (dn4 && ddn4 == 0) ddn4 = c;
      if (ddn2 != 0 && ddn4 != 0) break;
    end
    check({tag, "_ld_cycle"}, fld, 1);
    check({tag, "_first_shift"}, fsh, 2);
    check({tag, "_lane_r2"}, lc2, v.lane);
    check({tag, "_lane_r4"}, lc4, v.lane);
    check({tag, "_shifts_r2"}, nsh2, v.sh2);
    check({tag, "_done_cyc_r2"}, ddn2, v.dn2);
    check({tag, "_shifts_r4"}, nsh4, v.sh4);
    check({tag, "_done_cyc_r4"}, ddn4, v.dn4);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dn2) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask

  initial begin
    int seen;
    bit found;

    vt[0] = '{mode: 2'b00, lane: 2'b00, sh2: 32, dn2: 34, sh4: 16, dn4: 18};
    vt[1] = '{mode: 2'b01, lane: 2'b01, sh2: 16, dn2: 18, sh4:  8, dn4: 10};
    vt[2] = '{mode: 2'b10, lane: 2'b10, sh2:  8, dn2: 10, sh4:  4, dn4:  6};
    vt[3] = '{mode: 2'b11, lane: 2'b00, sh2: 32, dn2: 34, sh4: 16, dn4: 18};

    // Reset values, then a start accepted on the first edge after release.
    @(negedge clk);
    check("rst_start_ready", sr2, 1);
    check("rst_busy", bz2, 0);
    check("rst_done", dn2, 0);
    check("rst_count", cnt2, 0);
    check("rst_lane", lc2, 0);
    rst_n = 1'b1;
    start = 1'b1;
    mode  = 2'b10;
    @(negedge clk);
    check("first_start_ld", ld2, 1);
    check("first_start_lane", lc2, 2'b10);
    start = 1'b0;
    finish_op("first");

    for (int i = 0; i < 4; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Abort in RUN at count 5.
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (se2 && cnt2 == 5) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach_cnt5", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_start_ready", sr2, 1);
    check("abort_busy", bz2, 0);
    check("abort_count_held", cnt2, 5);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dn2 || dn4) seen = 1;
    end
    check("abort_no_done", seen, 0);
    run_vec(vt[0], "post_abort");

    // start held through DONE together with res_ack.
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b10;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dn2) begin
        found = 1;
        break;
      end
    end
    check("hold_start_done", found, 1);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("hold_start_idle", sr2, 1);
    check("hold_start_no_ld", ld2, 0);
    @(negedge clk);
    check("hold_start_second_ld", ld2, 1);
    start = 1'b0;
    finish_op("second");

    // Asynchronous reset at count 12, then no done after release.
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 30; c++) begin
      if (se2 && cnt2 == 12) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reach_cnt12", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_r2", {sr2, ld2, ca2, cc2, se2, li2, bz2, dn2, lc2, cnt2}, 15'h4000);
    check("async_rst_r4", {sr4, ld4, ca4, cc4, se4, li4, bz4, dn4, lc4, cnt4}, 15'h4000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dn2 || dn4) seen = 1;
    end
    check("rst_no_done", seen, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 9) < 3);
      mode    = 2'($urandom_range(0, 3));
      res_ack = ($urandom_range(0, 9) < 2);
      abort   = ($urandom_range(0, 99) < 3);
    end
    @(negedge clk);
    start   = 1'b0;
    res_ack = 1'b0;
    abort   = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
